brew_sequencer: RTL and testbench
=================================

Name: brew_sequencer

Overview:
- Controls the 3-bit down-counter (load/enable/up-down/preset) that times each dispensing phase of the coffee machine.
- On a start request it runs the recipe for the selected drink through up to three timed phases: COFFEE, MILK, WATER.
- For each phase it presets the counter, decrements it once per one-second tick, and drives the matching valve.
- It sits between the coin/selection front end and the valve drivers. The counter remains a separate instance; this block reads its count value back.

Parameters:
- ESP_COFFEE, 3, espresso coffee-phase seconds (0-7)
- LAT_COFFEE, 2, latte coffee-phase seconds
- LAT_MILK, 4, latte milk-phase seconds
- AME_COFFEE, 2, americano coffee-phase seconds
- AME_WATER, 5, americano water-phase seconds

Ports:
- Brew_seq_clock, in, 1, system clock
- Brew_seq_rst, in, 1, asynchronous active-high reset
- Brew_seq_start, in, 1, one-cycle brew request (already paid)
- Brew_seq_drink, in, 2, 0=espresso 1=latte 2=americano 3=invalid
- Brew_seq_cancel, in, 1, abort current brew
- Brew_seq_tick, in, 1, one-cycle pulse per second
- Brew_seq_cnt_value, in, 3, counter output fed back
- Brew_seq_cnt_LD, out, 1, counter load
- Brew_seq_cnt_EN, out, 1, counter enable
- Brew_seq_cnt_UD, out, 1, counter direction (1 = down)
- Brew_seq_cnt_pre, out, 3, counter preset value
- Brew_seq_coffee_open, out, 1, coffee valve
- Brew_seq_milk_open, out, 1, milk valve
- Brew_seq_water_open, out, 1, water valve
- Brew_seq_heater_on, out, 1, heater (used only by the optional feature)
- Brew_seq_busy, out, 1, brew in progress
- Brew_seq_done, out, 1, one-cycle completion pulse

Interface (already decided): one clock, Brew_seq_clock. Reset Brew_seq_rst is asynchronous and active-high.

Behaviour:
- States: IDLE, LOAD, RUN, DONE, plus a 2-bit phase register (COFFEE, MILK, WATER; HEAT with the optional feature). All state is registered.
- Outputs are decoded from state. The one exception is cnt_EN, which also gates on tick.
- Reset: state=IDLE; all outputs 0 except cnt_UD, which is constant 1.
- Drink latch: drink is latched on start; later changes to the drink input are ignored until IDLE.

IDLE:
- start with drink 0-2: latch drink, select the first phase with nonzero duration, go to LOAD.
- If every phase duration is 0, go straight to DONE.
- start with drink=3: ignored, stay in IDLE.

LOAD (exactly 1 cycle):
- cnt_LD=1, cnt_pre = current phase duration, busy=1.
- Next state is RUN. The counter shows the preset value in the first RUN cycle.

RUN:
- busy=1. The phase valve is on while cnt_value≠0.
- cnt_EN = tick & (cnt_value≠0), so the counter never wraps below 0.
- When cnt_value==0: advance to the next nonzero-duration phase in COFFEE→MILK→WATER order and go to LOAD. If no phase remains, go to DONE.
- Phase length is N ticks plus 2 cycles of overhead (LOAD cycle and the zero-detect cycle).

DONE:
- done=1 for one cycle, busy=0, then IDLE.

Start and cancel handling:
- start while busy: ignored.
- cancel in LOAD or RUN: next cycle is IDLE. cnt_LD=1 with cnt_pre=0 is issued in that IDLE cycle to clear the counter. Valves close immediately (combinationally with the state change). No done pulse.
- cancel in IDLE or DONE: no effect.
- cancel and start in the same IDLE cycle: cancel wins, start is dropped.
- Reset mid-brew: immediate return to IDLE with all outputs cleared.

Optional Feature:
- Macro: BREW_SEQUENCER_PREHEAT_EN.
- Defined: adds parameter PREHEAT (default 2) and a HEAT phase that runs before COFFEE for every valid drink, using the same LOAD/RUN mechanics. heater_on=1 while in HEAT RUN with cnt_value≠0. If PREHEAT=0 the phase is skipped.
- Undefined: no HEAT phase; heater_on is tied to 0.

Decomposition:
- Shared package brew_pkg:
  - state encoding constants (IDLE/LOAD/RUN/DONE)
  - phase codes (HEAT/COFFEE/MILK/WATER)
  - drink codes (ESPRESSO=0, LATTE=1, AMERICANO=2)
- Sub-module brew_recipe_rom: combinational mapping drink → {coffee, milk, water} durations from the parameters. It also provides the next-nonzero-phase lookup.

Test Plan:
- Espresso, tick every 4 clocks: start with drink=0 → LOAD with pre=3; coffee_open held for 3 ticks; no milk or water valve; done one cycle after cnt reaches 0; busy falls with done.
- Latte: drink=1 → coffee 2 ticks, then LOAD pre=4, milk 4 ticks; water never asserted; exactly one done pulse.
- Cancel during americano water phase with cnt=3 → next cycle IDLE, cnt_LD=1 with pre=0, valves 0, no done; a new start is then accepted.
- drink=3 start, and start while busy → ignored; state and outputs unchanged.
- Zero-duration phases: override LAT_MILK=0 → latte runs coffee only, then DONE; override all durations to 0 → start goes straight to DONE with a done pulse.
- Reset asserted mid RUN and asynchronous to the clock → all outputs 0 immediately. With BREW_SEQUENCER_PREHEAT_EN defined: heater_on for 2 ticks before coffee_open.

Source files
------------

// File: rtl/brew_pkg.sv
// Shared encodings for the brew sequencer: controller states, dispensing phases, drink codes.
package brew_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PH_HEAT   = 2'd0,
    PH_COFFEE = 2'd1,
    PH_MILK   = 2'd2,
    PH_WATER  = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    D_ESPRESSO  = 2'd0,
    D_LATTE     = 2'd1,
    D_AMERICANO = 2'd2,
    D_INVALID   = 2'd3
  } drink_t;

  localparam int DUR_W = 3;

endpackage

// File: rtl/brew_sequencer_if.sv
// Front-end / counter / valve signal bundle of the brew sequencer.
interface brew_sequencer_if;
  logic       Brew_seq_start;
  logic [1:0] Brew_seq_drink;
  logic       Brew_seq_cancel;
  logic       Brew_seq_tick;
  logic [2:0] Brew_seq_cnt_value;
  logic       Brew_seq_cnt_LD;
  logic       Brew_seq_cnt_EN;
  logic       Brew_seq_cnt_UD;
  logic [2:0] Brew_seq_cnt_pre;
  logic       Brew_seq_coffee_open;
  logic       Brew_seq_milk_open;
  logic       Brew_seq_water_open;
  logic       Brew_seq_heater_on;
  logic       Brew_seq_busy;
  logic       Brew_seq_done;

  modport master (
    output Brew_seq_start, Brew_seq_drink, Brew_seq_cancel, Brew_seq_tick, Brew_seq_cnt_value,
    input  Brew_seq_cnt_LD, Brew_seq_cnt_EN, Brew_seq_cnt_UD, Brew_seq_cnt_pre,
    input  Brew_seq_coffee_open, Brew_seq_milk_open, Brew_seq_water_open, Brew_seq_heater_on,
    input  Brew_seq_busy, Brew_seq_done
  );

  modport slave (
    input  Brew_seq_start, Brew_seq_drink, Brew_seq_cancel, Brew_seq_tick, Brew_seq_cnt_value,
    output Brew_seq_cnt_LD, Brew_seq_cnt_EN, Brew_seq_cnt_UD, Brew_seq_cnt_pre,
    output Brew_seq_coffee_open, Brew_seq_milk_open, Brew_seq_water_open, Brew_seq_heater_on,
    output Brew_seq_busy, Brew_seq_done
  );
endinterface

// File: rtl/brew_recipe_rom.sv
// Recipe table: drink/phase -> duration, plus search for the first nonzero phase at or after a start index.
module brew_recipe_rom
  import brew_pkg::*;
#(
  parameter int ESP_COFFEE = 3,
  parameter int LAT_COFFEE = 2,
  parameter int LAT_MILK   = 4,
  parameter int AME_COFFEE = 2,
  parameter int AME_WATER  = 5,
  parameter int HEAT_T     = 0
) (
  input  drink_t             dur_drink,
  input  phase_t             dur_phase,
  output logic [DUR_W-1:0]   dur,
  input  drink_t             srch_drink,
  input  logic [2:0]         srch_from,
  output logic               srch_found,
  output phase_t             srch_phase
);

  function automatic logic [DUR_W-1:0] lookup(drink_t d, phase_t p);
    logic [DUR_W-1:0] t;
    t = '0;
    case (p)
      PH_HEAT:   if (d != D_INVALID) t = DUR_W'(HEAT_T);
      PH_COFFEE: begin
        case (d)
          D_ESPRESSO:  t = DUR_W'(ESP_COFFEE);
          D_LATTE:     t = DUR_W'(LAT_COFFEE);
          D_AMERICANO: t = DUR_W'(AME_COFFEE);
          default:     t = '0;
        endcase
      end
      PH_MILK:   if (d == D_LATTE) t = DUR_W'(LAT_MILK);
      PH_WATER:  if (d == D_AMERICANO) t = DUR_W'(AME_WATER);
    endcase
    return t;
  endfunction

  assign dur = lookup(dur_drink, dur_phase);

  // Scan high to low so the lowest qualifying phase is the one left standing.
  always_comb begin
    srch_found = 1'b0;
    srch_phase = PH_HEAT;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) >= srch_from) && (lookup(srch_drink, phase_t'(2'(i))) != '0)) begin
        srch_found = 1'b1;
        srch_phase = phase_t'(2'(i));
      end
    end
  end

endmodule

// File: rtl/brew_sequencer.sv
// Brew sequencer: steps a drink recipe through timed phases using an external 3-bit down-counter.
// Optional pre-heat phase enabled by defining BREW_SEQUENCER_PREHEAT_EN.
module brew_sequencer
  import brew_pkg::*;
#(
  parameter int ESP_COFFEE = 3,
  parameter int LAT_COFFEE = 2,
  parameter int LAT_MILK   = 4,
  parameter int AME_COFFEE = 2,
  parameter int AME_WATER  = 5
`ifdef BREW_SEQUENCER_PREHEAT_EN
  , parameter int PREHEAT  = 2
`endif
) (
  input  logic             Brew_seq_clock,
  input  logic             Brew_seq_rst,
  brew_sequencer_if.slave  bus
);

`ifdef BREW_SEQUENCER_PREHEAT_EN
  localparam int HEAT_T = PREHEAT;
`else
  localparam int HEAT_T = 0;
`endif

  state_t           state, state_nx;
  phase_t           phase, phase_nx;
  drink_t           drink_q, drink_nx;
  logic             clr_q, clr_nx;
  logic [DUR_W-1:0] dur;
  drink_t           srch_drink;
  logic [2:0]       srch_from;
  logic             srch_found;
  phase_t           srch_phase;
  logic             cnt_nz, run;

  // In IDLE the search looks at the incoming drink from the first phase; otherwise past the current phase.
  assign srch_drink = (state == S_IDLE) ? drink_t'(bus.Brew_seq_drink) : drink_q;
  assign srch_from  = (state == S_IDLE) ? 3'd0 : ({1'b0, phase} + 3'd1);

  brew_recipe_rom #(
    .ESP_COFFEE (ESP_COFFEE),
    .LAT_COFFEE (LAT_COFFEE),
    .LAT_MILK   (LAT_MILK),
    .AME_COFFEE (AME_COFFEE),
    .AME_WATER  (AME_WATER),
    .HEAT_T     (HEAT_T)
  ) u_rom (
    .dur_drink  (drink_q),
    .dur_phase  (phase),
    .dur        (dur),
    .srch_drink (srch_drink),
    .srch_from  (srch_from),
    .srch_found (srch_found),
    .srch_phase (srch_phase)
  );

  always_ff @(posedge Brew_seq_clock or posedge Brew_seq_rst) begin
    if (Brew_seq_rst) begin
      state   <= S_IDLE;
      phase   <= PH_HEAT;
      drink_q <= D_ESPRESSO;
      clr_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      phase   <= phase_nx;
      drink_q <= drink_nx;
      clr_q   <= clr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    drink_nx = drink_q;
    clr_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.Brew_seq_start && !bus.Brew_seq_cancel && (bus.Brew_seq_drink != 2'd3)) begin
          drink_nx = drink_t'(bus.Brew_seq_drink);
          if (srch_found) begin
            phase_nx = srch_phase;
            state_nx = S_LOAD;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (bus.Brew_seq_cancel) begin
          state_nx = S_IDLE;
          clr_nx   = 1'b1;
        end else begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.Brew_seq_cancel) begin
          state_nx = S_IDLE;
          clr_nx   = 1'b1;
        end else if (!cnt_nz) begin
          if (srch_found) begin
            phase_nx = srch_phase;
            state_nx = S_LOAD;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_DONE: state_nx = S_IDLE;
    endcase
  end

  assign cnt_nz = (bus.Brew_seq_cnt_value != 3'd0);
  assign run    = (state == S_RUN);

  // clr_q marks the IDLE cycle right after a cancel, which zeroes the counter.
  assign bus.Brew_seq_cnt_LD      = (state == S_LOAD) || ((state == S_IDLE) && clr_q);
  assign bus.Brew_seq_cnt_pre     = (state == S_LOAD) ? dur : 3'd0;
  assign bus.Brew_seq_cnt_EN      = run && bus.Brew_seq_tick && cnt_nz;
  assign bus.Brew_seq_cnt_UD      = 1'b1;
  assign bus.Brew_seq_coffee_open = run && (phase == PH_COFFEE) && cnt_nz;
  assign bus.Brew_seq_milk_open   = run && (phase == PH_MILK) && cnt_nz;
  assign bus.Brew_seq_water_open  = run && (phase == PH_WATER) && cnt_nz;
  assign bus.Brew_seq_busy        = (state == S_LOAD) || run;
  assign bus.Brew_seq_done        = (state == S_DONE);

`ifdef BREW_SEQUENCER_PREHEAT_EN
  assign bus.Brew_seq_heater_on   = run && (phase == PH_HEAT) && cnt_nz;
`else
  assign bus.Brew_seq_heater_on   = 1'b0;
`endif

endmodule

// File: tb/tb_brew_sequencer.sv
// Bench for brew_sequencer: external counter model, recipe-table scoreboard, directed and random brews.
module tb_brew_sequencer;

`ifdef BREW_SEQUENCER_PREHEAT_EN
  localparam int PRE_T = 2;
`else
  localparam int PRE_T = 0;
`endif
  // Recipe durations per drink: {heat, coffee, milk, water}
  localparam int REC [3][4] = '{'{PRE_T, 3, 0, 0}, '{PRE_T, 2, 4, 0}, '{PRE_T, 2, 0, 5}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  int   tick_mode = 0;
  int   tick_ctr = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  brew_sequencer_if b0 ();
  brew_sequencer_if b1 ();
  brew_sequencer_if b2 ();

  brew_sequencer u0 (.Brew_seq_clock(clk), .Brew_seq_rst(rst), .bus(b0.slave));
  brew_sequencer #(.LAT_MILK(0)) u1 (.Brew_seq_clock(clk), .Brew_seq_rst(rst), .bus(b1.slave));
  brew_sequencer #(
    .ESP_COFFEE(0), .LAT_COFFEE(0), .LAT_MILK(0), .AME_COFFEE(0), .AME_WATER(0)
`ifdef BREW_SEQUENCER_PREHEAT_EN
    , .PREHEAT(0)
`endif
  ) u2 (.Brew_seq_clock(clk), .Brew_seq_rst(rst), .bus(b2.slave));

  assign b0.Brew_seq_tick = tick;
  assign b1.Brew_seq_tick = tick;
  assign b2.Brew_seq_tick = tick;

  function automatic logic [2:0] cnt_nx(logic [2:0] c, logic ld, logic en, logic ud, logic [2:0] pre);
    if (ld) return pre;
    if (en) return ud ? c - 3'd1 : c + 3'd1;
    return c;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) b0.Brew_seq_cnt_value <= '0;
    else b0.Brew_seq_cnt_value <= cnt_nx(b0.Brew_seq_cnt_value, b0.Brew_seq_cnt_LD, b0.Brew_seq_cnt_EN, b0.Brew_seq_cnt_UD, b0.Brew_seq_cnt_pre);
  always @(posedge clk or posedge rst)
    if (rst) b1.Brew_seq_cnt_value <= '0;
    else b1.Brew_seq_cnt_value <= cnt_nx(b1.Brew_seq_cnt_value, b1.Brew_seq_cnt_LD, b1.Brew_seq_cnt_EN, b1.Brew_seq_cnt_UD, b1.Brew_seq_cnt_pre);
  always @(posedge clk or posedge rst)
    if (rst) b2.Brew_seq_cnt_value <= '0;
    else b2.Brew_seq_cnt_value <= cnt_nx(b2.Brew_seq_cnt_value, b2.Brew_seq_cnt_LD, b2.Brew_seq_cnt_EN, b2.Brew_seq_cnt_UD, b2.Brew_seq_cnt_pre);

  always @(posedge clk) begin
    #1;
    tick_ctr = tick_ctr + 1;
    case (tick_mode)
      1:       tick = (tick_ctr % 4 == 0);
      2:       tick = ($urandom_range(0, 2) == 0);
      default: tick = 1'b0;
    endcase
  end

  // Output vector: {LD, EN, UD, pre[2:0], coffee, milk, water, heater, busy, done}
  logic [11:0] o0, o1, o2;
  assign o0 = {b0.Brew_seq_cnt_LD, b0.Brew_seq_cnt_EN, b0.Brew_seq_cnt_UD, b0.Brew_seq_cnt_pre,
               b0.Brew_seq_coffee_open, b0.Brew_seq_milk_open, b0.Brew_seq_water_open,
               b0.Brew_seq_heater_on, b0.Brew_seq_busy, b0.Brew_seq_done};
  assign o1 = {b1.Brew_seq_cnt_LD, b1.Brew_seq_cnt_EN, b1.Brew_seq_cnt_UD, b1.Brew_seq_cnt_pre,
               b1.Brew_seq_coffee_open, b1.Brew_seq_milk_open, b1.Brew_seq_water_open,
               b1.Brew_seq_heater_on, b1.Brew_seq_busy, b1.Brew_seq_done};
  assign o2 = {b2.Brew_seq_cnt_LD, b2.Brew_seq_cnt_EN, b2.Brew_seq_cnt_UD, b2.Brew_seq_cnt_pre,
               b2.Brew_seq_coffee_open, b2.Brew_seq_milk_open, b2.Brew_seq_water_open,
               b2.Brew_seq_heater_on, b2.Brew_seq_busy, b2.Brew_seq_done};

  // Scoreboard collection for u0, sampled mid-cycle
  int c_tk, m_tk, w_tk, h_tk, c_op, m_op, w_op, h_op, done_n, clr_n, err_n;
  logic [2:0] ld_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (b0.Brew_seq_cnt_LD) begin
        if (b0.Brew_seq_cnt_pre != 3'd0) ld_q.push_back(b0.Brew_seq_cnt_pre);
        else clr_n = clr_n + 1;
      end
      if (b0.Brew_seq_coffee_open) begin c_op = c_op + 1; if (tick) c_tk = c_tk + 1; end
      if (b0.Brew_seq_milk_open)   begin m_op = m_op + 1; if (tick) m_tk = m_tk + 1; end
      if (b0.Brew_seq_water_open)  begin w_op = w_op + 1; if (tick) w_tk = w_tk + 1; end
      if (b0.Brew_seq_heater_on)   begin h_op = h_op + 1; if (tick) h_tk = h_tk + 1; end
      if (b0.Brew_seq_done) done_n = done_n + 1;
      if ($countones({b0.Brew_seq_coffee_open, b0.Brew_seq_milk_open, b0.Brew_seq_water_open, b0.Brew_seq_heater_on}) > 1)
        err_n = err_n + 1;
      if (b0.Brew_seq_busy && b0.Brew_seq_done) err_n = err_n + 1;
      if (b0.Brew_seq_cnt_EN && (b0.Brew_seq_cnt_value == 3'd0)) err_n = err_n + 1;
      if ((b0.Brew_seq_coffee_open | b0.Brew_seq_milk_open | b0.Brew_seq_water_open | b0.Brew_seq_heater_on) && !b0.Brew_seq_busy)
        err_n = err_n + 1;
    end
  end

  task automatic clear_mon();
    c_tk = 0; m_tk = 0; w_tk = 0; h_tk = 0;
    c_op = 0; m_op = 0; w_op = 0; h_op = 0;
    done_n = 0; clr_n = 0; err_n = 0;
    ld_q.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_done0(input string tag, input int limit);
    int n;
    n = 0;
    while (!b0.Brew_seq_done && n < limit) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, 32'(n < limit), 32'd1);
  endtask

  function automatic int first_pre(input int d);
    for (int p = 0; p < 4; p++) if (REC[d][p] != 0) return REC[d][p];
    return 0;
  endfunction

  // Compare one completed brew on u0 against the recipe table
  task automatic check_brew(input string tag, input int d);
    logic [2:0] e[$];
    for (int p = 0; p < 4; p++) if (REC[d][p] != 0) e.push_back(3'(REC[d][p]));
    check({tag, "_ld_count"}, ld_q.size(), e.size());
    for (int i = 0; i < e.size() && i < ld_q.size(); i++) check({tag, "_ld_pre"}, 32'(ld_q[i]), 32'(e[i]));
    check({tag, "_heat_ticks"}, h_tk, REC[d][0]);
    check({tag, "_coffee_ticks"}, c_tk, REC[d][1]);
    check({tag, "_milk_ticks"}, m_tk, REC[d][2]);
    check({tag, "_water_ticks"}, w_tk, REC[d][3]);
    check({tag, "_done_pulses"}, done_n, 1);
    check({tag, "_invariants"}, err_n, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, z, d, inj, ld1, m1, c1;
    b0.Brew_seq_start = 0; b0.Brew_seq_drink = 0; b0.Brew_seq_cancel = 0;
    b1.Brew_seq_start = 0; b1.Brew_seq_drink = 0; b1.Brew_seq_cancel = 0;
    b2.Brew_seq_start = 0; b2.Brew_seq_drink = 0; b2.Brew_seq_cancel = 0;
    clear_mon();
    step(3);
    check("reset_outs", o0, 12'h200);
    #1 rst = 1'b0;
    step();
    check("idle_outs", o0, 12'h200);

    // Espresso, tick every 4 clocks, cycle-exact completion
    tick_mode = 1;
    clear_mon();
    b0.Brew_seq_drink = 2'd0; b0.Brew_seq_start = 1'b1;
    step();
    b0.Brew_seq_start = 1'b0;
    check("esp_load", {b0.Brew_seq_cnt_LD, b0.Brew_seq_cnt_pre, b0.Brew_seq_busy}, {1'b1, 3'(first_pre(0)), 1'b1});
    n = 0; z = -1;
    while (!b0.Brew_seq_done && n < 100) begin
      if (b0.Brew_seq_busy && b0.Brew_seq_cnt_value == 3'd0) z = n;
      step();
      n++;
    end
    check("esp_done_seen", 32'(n < 100), 32'd1);
    check("esp_done_latency", n, z + 1);
    check("esp_busy_at_done", b0.Brew_seq_busy, 1'b0);
    step();
    check("esp_after_done", o0, 12'h200);
    check_brew("esp", 0);
    check("esp_milk_water_open", m_op + w_op, 0);

    // Latte; drink input changes and a second start during the brew are ignored
    clear_mon();
    b0.Brew_seq_drink = 2'd1; b0.Brew_seq_start = 1'b1;
    step();
    b0.Brew_seq_start = 1'b0; b0.Brew_seq_drink = 2'd2;
    step(3);
    b0.Brew_seq_start = 1'b1; b0.Brew_seq_drink = 2'd0;
    step();
    b0.Brew_seq_start = 1'b0;
    wait_done0("lat", 200);
    step();
    check_brew("lat", 1);
    check("lat_water_open", w_op, 0);

    // Invalid drink
    clear_mon();
    b0.Brew_seq_drink = 2'd3; b0.Brew_seq_start = 1'b1;
    step();
    b0.Brew_seq_start = 1'b0;
    check("inv_outs", o0, 12'h200);
    step(3);
    check("inv_no_done", done_n, 0);
    check("inv_no_load", ld_q.size(), 0);

    // Cancel americano in water phase at count 3
    clear_mon();
    b0.Brew_seq_drink = 2'd2; b0.Brew_seq_start = 1'b1;
    step();
    b0.Brew_seq_start = 1'b0;
    n = 0;
    while (!(b0.Brew_seq_water_open && b0.Brew_seq_cnt_value == 3'd3) && n < 200) begin
      step();
      n++;
    end
    check("ame_water3_seen", 32'(n < 200), 32'd1);
    b0.Brew_seq_cancel = 1'b1;
    step();
    b0.Brew_seq_cancel = 1'b0;
    check("cancel_outs", o0, 12'hA00);
    step();
    check("cancel_next", o0, 12'h200);
    check("cancel_cnt_cleared", b0.Brew_seq_cnt_value, 3'd0);
    step(4);
    check("cancel_no_done", done_n, 0);
    check("cancel_clear_loads", clr_n, 1);
    b0.Brew_seq_drink = 2'd0; b0.Brew_seq_start = 1'b1;
    step();
    b0.Brew_seq_start = 1'b0;
    check("restart_load", {b0.Brew_seq_cnt_LD, b0.Brew_seq_cnt_pre, b0.Brew_seq_busy}, {1'b1, 3'(first_pre(0)), 1'b1});
    wait_done0("restart", 200);
    step();

    // Cancel and start together in IDLE: cancel wins
    b0.Brew_seq_cancel = 1'b1; b0.Brew_seq_start = 1'b1; b0.Brew_seq_drink = 2'd1;
    step();
    b0.Brew_seq_cancel = 1'b0; b0.Brew_seq_start = 1'b0;
    check("cancel_start_outs", o0, 12'h200);
    step(2);
    check("cancel_start_idle", o0, 12'h200);

    // Asynchronous reset mid RUN
    b0.Brew_seq_drink = 2'd0; b0.Brew_seq_start = 1'b1;
    step();
    b0.Brew_seq_start = 1'b0;
    n = 0;
    while (!b0.Brew_seq_coffee_open && n < 100) begin
      step();
      n++;
    end
    check("rst_run_seen", 32'(n < 100), 32'd1);
    #2 rst = 1'b1;
    #2 check("async_rst_outs", o0, 12'h200);
    #2 rst = 1'b0;
    step();
    check("post_rst_idle", o0, 12'h200);

    // LAT_MILK = 0 variant: latte is coffee only
    b1.Brew_seq_drink = 2'd1; b1.Brew_seq_start = 1'b1;
    step();
    b1.Brew_seq_start = 1'b0;
    n = 0; ld1 = 0; m1 = 0; c1 = 0;
    while (!b1.Brew_seq_done && n < 100) begin
      if (b1.Brew_seq_cnt_LD) ld1++;
      if (b1.Brew_seq_milk_open) m1++;
      if (b1.Brew_seq_coffee_open && tick) c1++;
      step();
      n++;
    end
    check("u1_done_seen", 32'(n < 100), 32'd1);
    check("u1_loads", ld1, (PRE_T > 0) ? 2 : 1);
    check("u1_milk_open", m1, 0);
    check("u1_coffee_ticks", c1, 2);
    step();
    check("u1_idle", o1, 12'h200);

    // All-zero variant: start goes straight to DONE
    b2.Brew_seq_drink = 2'd2; b2.Brew_seq_start = 1'b1;
    step();
    b2.Brew_seq_start = 1'b0;
    check("u2_done", o2, 12'h201);
    step();
    check("u2_idle", o2, 12'h200);

    // Random drinks, random tick spacing, noisy inputs while busy
    tick_mode = 2;
    for (int k = 0; k < 25; k++) begin
      d = $urandom_range(0, 3);
      clear_mon();
      b0.Brew_seq_drink = 2'(d); b0.Brew_seq_start = 1'b1;
      step();
      b0.Brew_seq_start = 1'b0;
      if (d == 3) begin
        step(2);
        check("rnd_inv_busy", b0.Brew_seq_busy, 1'b0);
        check("rnd_inv_done", done_n, 0);
      end else begin
        inj = $urandom_range(1, 8);
        n = 0;
        while (!b0.Brew_seq_done && n < 300) begin
          b0.Brew_seq_drink = 2'($urandom_range(0, 3));
          b0.Brew_seq_start = (n == inj) && b0.Brew_seq_busy;
          step();
          n++;
        end
        b0.Brew_seq_start = 1'b0;
        check("rnd_done_seen", 32'(n < 300), 32'd1);
        step();
        check_brew("rnd", d);
      end
      step($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
